// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared types, write-enable encodings and address helpers for
//               the direct-mapped write-through data cache.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        WAIT  = 2'd3
    } state_t;

    // Operation encoding shared by CPU and memory: bit0 = store, bit1 = byte
    localparam logic [2:0] WE_LW = 3'b000;
    localparam logic [2:0] WE_LB = 3'b010;
    localparam logic [2:0] WE_SW = 3'b001;
    localparam logic [2:0] WE_SB = 3'b011;

    // Line index: the bits just above the byte offset
    function automatic logic [31:0] index_of(input logic [31:0] addr,
                                             input int unsigned idx_bits);
        logic [31:0] mask;
        mask = (32'd1 << idx_bits) - 32'd1;
        return (addr >> 2) & mask;
    endfunction

    // Tag: the significant address bits above the index
    function automatic logic [31:0] tag_of(input logic [31:0] addr,
                                           input int unsigned idx_bits,
                                           input int unsigned addr_bits);
        logic [31:0] mask;
        mask = (32'd1 << (addr_bits - 2 - idx_bits)) - 32'd1;
        return (addr >> (2 + idx_bits)) & mask;
    endfunction

endpackage : cache_pkg
`default_nettype wire

// File: rtl/cache_array.sv
`default_nettype none
// ============================================================================
// Module      : cache_array
// Description : Valid/tag/data storage for the direct-mapped cache. One
//               combinational read port, one byte-masked write port with an
//               optional valid/tag update. Valid bits clear on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_array #(
    parameter int SETS  = 8,
    parameter int TAG_W = 12,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [3:0]       wr_be,
    input  logic [31:0]      wr_data,
    input  logic             wr_set_valid,
    input  logic [TAG_W-1:0] wr_tag
);

    logic [SETS-1:0]  r_valid;
    logic [TAG_W-1:0] r_tag  [SETS];
    logic [31:0]      r_data [SETS];

    // Asynchronous read of the addressed line
    always_comb begin
        rd_valid = r_valid[rd_idx];
        rd_tag   = r_tag[rd_idx];
        rd_data  = r_data[rd_idx];
    end

    // Line update: byte-lane merge into data, optional validate with new tag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    r_data[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
            if (wr_set_valid) begin
                r_valid[wr_idx] <= 1'b1;
                r_tag[wr_idx]   <= wr_tag;
            end
        end
    end

endmodule : cache_array
`default_nettype wire

// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
// Module      : data_cache
// Description : Direct-mapped, write-through, no-write-allocate data cache.
//               Load hits return combinationally; misses fill one word from
//               memory; stores always write through and wait for mem_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module data_cache
    import cache_pkg::*;
#(
    parameter int SETS          = 8,
    parameter int ADDRESS_WIDTH = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic [2:0]  cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wd,
    output logic [31:0] cpu_rd,
    output logic        stall,
    output logic [2:0]  mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    input  logic        mem_ready
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = ADDRESS_WIDTH - 2 - IDX_W;

    state_t             state;
    state_t             next_state;
    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   addr_tag;
    logic               line_valid;
    logic [TAG_W-1:0]   line_tag;
    logic [31:0]        line_data;
    logic               hit;
    logic               wr_en;
    logic [3:0]         wr_be;
    logic [31:0]        wr_data;
    logic               wr_set_valid;
    logic [7:0]         sel_byte;

    // Address split and hit compare
    always_comb begin
        idx      = IDX_W'(index_of(cpu_addr, IDX_W));
        addr_tag = TAG_W'(tag_of(cpu_addr, IDX_W, ADDRESS_WIDTH));
        hit      = line_valid && (line_tag == addr_tag);
    end

    cache_array #(
        .SETS  (SETS),
        .TAG_W (TAG_W),
        .IDX_W (IDX_W)
    ) u_array (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_idx       (idx),
        .rd_valid     (line_valid),
        .rd_tag       (line_tag),
        .rd_data      (line_data),
        .wr_en        (wr_en),
        .wr_idx       (idx),
        .wr_be        (wr_be),
        .wr_data      (wr_data),
        .wr_set_valid (wr_set_valid),
        .wr_tag       (addr_tag)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, stall, memory-side muxing and line write control
    always_comb begin
        next_state   = state;
        stall        = 1'b0;
        mem_we       = WE_LW;
        mem_a        = cpu_addr;
        mem_wd       = cpu_wd;
        wr_en        = 1'b0;
        wr_be        = 4'b0000;
        wr_data      = cpu_wd;
        wr_set_valid = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (cpu_we[0]) begin
                        stall      = 1'b1;
                        next_state = WRITE;
                    end else if (!hit) begin
                        stall      = 1'b1;
                        next_state = FILL;
                    end
                end
            end
            FILL: begin
                stall        = 1'b1;
                mem_a        = {cpu_addr[31:2], 2'b00};
                wr_en        = 1'b1;
                wr_be        = 4'b1111;
                wr_data      = mem_rd;
                wr_set_valid = 1'b1;
                next_state   = IDLE;
            end
            WRITE: begin
                stall      = 1'b1;
                mem_we     = cpu_we;
                // No-write-allocate: only a resident line is touched
                if (hit) begin
                    wr_en = 1'b1;
                    if (cpu_we[1]) begin
                        wr_be   = 4'b0001 << cpu_addr[1:0];
                        wr_data = {4{cpu_wd[7:0]}};
                    end else begin
                        wr_be   = 4'b1111;
                    end
                end
                next_state = WAIT;
            end
            WAIT: begin
                stall = !mem_ready;
                if (mem_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        // Quiet the CPU and memory sides while reset is held
        if (!rst_n) begin
            stall  = 1'b0;
            mem_we = WE_LW;
            wr_en  = 1'b0;
        end
    end

    // Load data: whole word for lw, zero-extended addressed byte for lb
    always_comb begin
        sel_byte = line_data[8*cpu_addr[1:0] +: 8];
        if (!rst_n) begin
            cpu_rd = 32'd0;
        end else if (cpu_we[1]) begin
            cpu_rd = {24'd0, sel_byte};
        end else begin
            cpu_rd = line_data;
        end
    end

endmodule : data_cache
`default_nettype wire
